parc_core_fetch_buffer: RTL and testbench



---
 rtl/parc_core_fetch_buffer_pkg.sv | 8 +
 rtl/parc_core_fetch_buffer_if.sv | 21 ++
 rtl/parc_core_fetch_buffer_queue.sv | 42 ++++
 rtl/parc_core_fetch_buffer.sv | 44 ++++
 tb/tb_parc_core_fetch_buffer.sv | 107 ++++++++++
 5 files changed

// File: rtl/parc_core_fetch_buffer_pkg.sv
// parc_fetch_pkg: shared fetch constants, counter sizing and squash-source encodings
package parc_fetch_pkg;
  localparam logic [31:0] PARC_NOP = 32'h0000_0000;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef enum logic [1:0] {SQ_NONE, SQ_BR_X, SQ_J_D, SQ_JR_D} squash_src_e;
endpackage

// File: rtl/parc_core_fetch_buffer_if.sv
// parc_core_fetch_buffer_if: imem request/response, squash and Decode handshake bundle
// master = fetch buffer side, slave = memory/ctrl/Decode side
interface parc_core_fetch_buffer_if;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic        imemresp_val;
  logic [31:0] imemresp_msg_data;
  logic        imemresp_rdy;
  logic        squash_Fhl;
  logic        inst_val_Dhl;
  logic [31:0] inst_Dhl;
  logic        inst_rdy_Dhl;
  modport master (
    output imemreq_val, imemresp_rdy, inst_val_Dhl, inst_Dhl,
    input  imemreq_rdy, imemresp_val, imemresp_msg_data, squash_Fhl, inst_rdy_Dhl
  );
  modport slave (
    input  imemreq_val, imemresp_rdy, inst_val_Dhl, inst_Dhl,
    output imemreq_rdy, imemresp_val, imemresp_msg_data, squash_Fhl, inst_rdy_Dhl
  );
endinterface

// File: rtl/parc_core_fetch_buffer_queue.sv
// parc_fetch_queue: DEPTH-entry circular instruction buffer with enq/deq/flush, count and head outputs
// head shows NOP when empty; flush wins over same-cycle enq/deq
module parc_fetch_queue
  import parc_fetch_pkg::*;
#(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = PARC_NOP
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enq,
  input  logic [31:0]               enq_data,
  input  logic                      deq,
  input  logic                      flush,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [31:0]               head
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] hd, tl;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else if (flush) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      if (enq) tl <= nxt(tl);
      if (deq) hd <= nxt(hd);
      count <= count + CW'(enq) - CW'(deq);
    end
  always_ff @(posedge clk)
    if (enq && !flush) mem[tl] <= enq_data;
  assign head = count == '0 ? NOP : mem[hd];
endmodule

// File: rtl/parc_core_fetch_buffer.sv
// parc_core_fetch_buffer: imem credit throttle, response queue and squash drop bookkeeping for Decode
// ports: clk, reset (async active-low), f = imem req/resp + squash + Decode handshake (master)
module parc_core_fetch_buffer
  import parc_fetch_pkg::*;
#(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = PARC_NOP
) (
  input logic                      clk,
  input logic                      reset,
  parc_core_fetch_buffer_if.master f
);
  localparam int CW = cnt_w(DEPTH);
  logic [CW-1:0] inflight, drop, count, inflight_nx;
  logic          req_fire, enq, deq;
  // credits cover doomed responses too, so queue space always exists for every return
  assign f.imemreq_val  = reset && ({1'b0, inflight} + {1'b0, count} < (CW+1)'(DEPTH));
  assign f.imemresp_rdy = 1'b1;
  assign f.inst_val_Dhl = count != '0;
  assign req_fire       = f.imemreq_val && f.imemreq_rdy;
  assign enq            = f.imemresp_val && drop == '0 && !f.squash_Fhl;
  assign deq            = f.inst_val_Dhl && f.inst_rdy_Dhl;
  assign inflight_nx    = inflight + CW'(req_fire) - CW'(f.imemresp_val);
  // on squash everything still outstanding is wrong-path except the redirect request fired now
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nx;
      drop     <= f.squash_Fhl ? inflight_nx - CW'(req_fire) : drop - CW'(f.imemresp_val && drop != '0);
    end
  parc_fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .enq      (enq),
    .enq_data (f.imemresp_msg_data),
    .deq      (deq),
    .flush    (f.squash_Fhl),
    .count    (count),
    .head     (f.inst_Dhl)
  );
  a_resp_credit: assert property (@(posedge clk) disable iff (!reset) f.imemresp_val |-> inflight != '0);
endmodule

// File: tb/tb_parc_core_fetch_buffer.sv
// tb_parc_core_fetch_buffer: directed vectors for the fetch buffer (DEPTH=2, NOP=0)
module tb_parc_core_fetch_buffer;
  import parc_fetch_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vecs = 0, errs = 0, n = 0;
  always #5 clk = ~clk;
  localparam logic [31:0] A = 32'hA000_0001, B = 32'hB000_0002, C = 32'hC000_0003, D = 32'hD000_0004;
  localparam logic [31:0] W1 = 32'h0BAD_0001, W2 = 32'h0BAD_0002, X = 32'h1111_0005, Y = 32'h0BAD_0003;
  localparam logic [31:0] Z = 32'h2222_0006, P = 32'h3333_0007, Q = 32'h0BAD_0004, R = 32'h4444_0008;
  localparam logic [31:0] S = 32'h5555_0009, T = 32'h6666_000A;
  parc_core_fetch_buffer_if bus();
  parc_core_fetch_buffer #(.DEPTH(2), .NOP(PARC_NOP)) dut (.clk(clk), .reset(reset), .f(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rr, input logic rv, input logic [31:0] rd, input logic sq, input logic dr,
                      input int ei, input int ed, input int ec, input logic ev, input logic [31:0] eo, input logic eq);
    bus.imemreq_rdy       = rr;
    bus.imemresp_val      = rv;
    bus.imemresp_msg_data = rd;
    bus.squash_Fhl        = sq;
    bus.inst_rdy_Dhl      = dr;
    @(posedge clk);
    #1;
    n++;
    chk($sformatf("v%0d.inflight", n), 32'(dut.inflight), ei);
    chk($sformatf("v%0d.drop", n), 32'(dut.drop), ed);
    chk($sformatf("v%0d.count", n), 32'(dut.count), ec);
    chk($sformatf("v%0d.inst_val", n), 32'(bus.inst_val_Dhl), 32'(ev));
    chk($sformatf("v%0d.inst", n), bus.inst_Dhl, eo);
    chk($sformatf("v%0d.req_val", n), 32'(bus.imemreq_val), 32'(eq));
    bus.imemresp_val = 1'b0;
    bus.squash_Fhl   = 1'b0;
  endtask
  initial begin
    bus.imemreq_rdy = 0; bus.imemresp_val = 0; bus.imemresp_msg_data = 0;
    bus.squash_Fhl = 0; bus.inst_rdy_Dhl = 0;
    #2;
    chk("rst.req_val", 32'(bus.imemreq_val), 0);
    chk("rst.inst_val", 32'(bus.inst_val_Dhl), 0);
    chk("rst.inst", bus.inst_Dhl, PARC_NOP);
    chk("rst.resp_rdy", 32'(bus.imemresp_rdy), 1);
    #6 reset = 1'b1;
    #1 chk("rel.req_val", 32'(bus.imemreq_val), 1);
    //   rr rv data sq dr   inf drp cnt val inst  req
    // fill, latency 1
    step(1, 0, 0,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(1, 1, A,  0, 1,  1, 0, 1, 1, A, 0);
    step(1, 1, B,  0, 1,  0, 0, 1, 1, B, 1);
    step(1, 0, 0,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(1, 1, C,  0, 1,  1, 0, 1, 1, C, 0);
    // back-pressure for 5 cycles: queue saturates, no requests
    step(1, 1, D,  0, 0,  0, 0, 2, 1, C, 0);
    step(1, 0, 0,  0, 0,  0, 0, 2, 1, C, 0);
    step(1, 0, 0,  0, 0,  0, 0, 2, 1, C, 0);
    step(1, 0, 0,  0, 0,  0, 0, 2, 1, C, 0);
    step(1, 0, 0,  0, 0,  0, 0, 2, 1, C, 0);
    step(1, 0, 0,  0, 1,  0, 0, 1, 1, D, 1);
    step(1, 0, 0,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    // two in flight, squash: both old responses dropped, X first valid
    step(1, 0, 0,  0, 1,  2, 0, 0, 0, PARC_NOP, 0);
    step(1, 0, 0,  1, 1,  2, 2, 0, 0, PARC_NOP, 0);
    step(1, 1, W1, 0, 1,  1, 1, 0, 0, PARC_NOP, 1);
    step(1, 1, W2, 0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(0, 1, X,  0, 1,  0, 0, 1, 1, X, 1);
    // squash with the redirect request firing in the same cycle
    step(1, 0, 0,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(1, 0, 0,  1, 1,  2, 1, 0, 0, PARC_NOP, 0);
    step(1, 1, Y,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(0, 1, Z,  0, 0,  0, 0, 1, 1, Z, 1);
    // squash with queued P, response Q and dequeue in the same cycle
    step(1, 0, 0,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(0, 1, P,  0, 1,  0, 0, 1, 1, P, 1);
    step(1, 0, 0,  0, 0,  1, 0, 1, 1, P, 0);
    step(1, 1, Q,  1, 1,  0, 0, 0, 0, PARC_NOP, 1);
    step(1, 0, 0,  0, 0,  1, 0, 0, 0, PARC_NOP, 1);
    step(0, 1, R,  0, 0,  0, 0, 1, 1, R, 1);
    step(0, 0, 0,  0, 1,  0, 0, 0, 0, PARC_NOP, 1);
    // memory stall with one request outstanding
    step(1, 0, 0,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(0, 0, 0,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(0, 0, 0,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(0, 0, 0,  0, 1,  1, 0, 0, 0, PARC_NOP, 1);
    step(1, 1, S,  0, 0,  1, 0, 1, 1, S, 0);
    // async reset mid-cycle with count=1, inflight=1
    bus.imemreq_rdy = 0;
    #3 reset = 1'b0;
    #1;
    chk("arst.inst_val", 32'(bus.inst_val_Dhl), 0);
    chk("arst.inst", bus.inst_Dhl, PARC_NOP);
    chk("arst.req_val", 32'(bus.imemreq_val), 0);
    chk("arst.resp_rdy", 32'(bus.imemresp_rdy), 1);
    chk("arst.inflight", 32'(dut.inflight), 0);
    chk("arst.count", 32'(dut.count), 0);
    #1 reset = 1'b1;
    #1 chk("arel.req_val", 32'(bus.imemreq_val), 1);
    step(1, 0, 0,  0, 0,  1, 0, 0, 0, PARC_NOP, 1);
    step(0, 1, T,  0, 0,  0, 0, 1, 1, T, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
